// File: rtl/mips_multicycle_sequencer_if.sv
// Control/bus bundle between the multi-cycle MIPS sequencer and its datapath.
// The master modport is the sequencer side; the slave modport is the datapath/memory side.
interface mips_multicycle_sequencer_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       pc_is_zero;
  logic       waitrequest;
  logic       mem_read;
  logic       mem_write;
  logic       addr_sel;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic [1:0] pc_src;
  logic       alu_src;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       active;
  logic       fault;

  modport master (
    input  opcode, funct, pc_is_zero, waitrequest,
    output mem_read, mem_write, addr_sel, ir_write, pc_write, pc_write_cond,
           branch_ne, pc_src, alu_src, reg_dst, mem_to_reg, reg_write, active, fault
  );

  modport slave (
    output opcode, funct, pc_is_zero, waitrequest,
    input  mem_read, mem_write, addr_sel, ir_write, pc_write, pc_write_cond,
           branch_ne, pc_src, alu_src, reg_dst, mem_to_reg, reg_write, active, fault
  );
endinterface

// File: rtl/mips_multicycle_sequencer.sv
// Main control FSM of the multi-cycle MIPS datapath: fetch/decode/exec/mem/wb sequencing,
// shared-bus strobes with waitrequest stalls and an optional stall timeout.
module mips_multicycle_sequencer #(
  parameter int MAX_WAIT = 0,
  parameter int WAIT_W   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_sequencer_if.master   bus
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] C_ILL    = 4'd0;
  localparam logic [3:0] C_RTYPE  = 4'd1;
  localparam logic [3:0] C_JR     = 4'd2;
  localparam logic [3:0] C_IALU   = 4'd3;
  localparam logic [3:0] C_LOAD   = 4'd4;
  localparam logic [3:0] C_STORE  = 4'd5;
  localparam logic [3:0] C_BRANCH = 4'd6;
  localparam logic [3:0] C_J      = 4'd7;
  localparam logic [3:0] C_JAL    = 4'd8;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  function automatic logic [3:0] classify(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] c;
    c = C_ILL;
    if (op == 6'b000000) begin
      case (fn)
        6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
        6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011: c = C_RTYPE;
        6'b001000:                                             c = C_JR;
        default:                                               c = C_ILL;
      endcase
    end else if (op[5:3] == 3'b001) begin
      c = C_IALU;
    end else if (op[5:3] == 3'b100) begin
      c = C_LOAD;
    end else begin
      case (op)
        6'b101011:            c = C_STORE;
        6'b000100, 6'b000101: c = C_BRANCH;
        6'b000010:            c = C_J;
        6'b000011:            c = C_JAL;
        default:              c = C_ILL;
      endcase
    end
    return c;
  endfunction

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  logic [3:0]        cls;
  logic              bus_access;

  logic       mem_read, mem_write, addr_sel, ir_write, pc_write, pc_write_cond;
  logic       branch_ne, alu_src, reg_write;
  logic [1:0] pc_src, reg_dst, mem_to_reg;

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    fault_d       = fault_q;
    bus_access    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    addr_sel      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 2'b00;
    alu_src       = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    cls           = classify(bus.opcode, bus.funct);

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.pc_is_zero) begin
          state_d = S_HALT;
        end else begin
          mem_read   = 1'b1;
          bus_access = 1'b1;
          if (!bus.waitrequest) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (cls == C_ILL) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_RTYPE: state_d = S_WB;
          C_IALU: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          C_BRANCH: begin
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
            branch_ne     = bus.opcode[0];
            state_d       = S_FETCH;
          end
          C_J: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_FETCH;
          end
          C_JR: begin
            pc_write = 1'b1;
            pc_src   = 2'b11;
            state_d  = S_FETCH;
          end
          // The link register is written in WB from the PC+4 latched before this jump.
          C_JAL: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_WB;
          end
          default: begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        addr_sel   = 1'b1;
        bus_access = 1'b1;
        mem_read   = (cls == C_LOAD);
        mem_write  = (cls == C_STORE);
        if (!bus.waitrequest) state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        case (cls)
          C_RTYPE: reg_dst = 2'b01;
          C_LOAD:  mem_to_reg = 2'b01;
          C_JAL: begin
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
          default: reg_dst = 2'b00;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // A stall always keeps the same state, so the counter only survives consecutive stalls.
    if (bus_access && bus.waitrequest) begin
      wait_d = sat_inc(wait_q);
      if ((MAX_WAIT != 0) && (wait_q == WAIT_LAST)) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.addr_sel      = addr_sel;
  assign bus.ir_write      = ir_write;
  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.branch_ne     = branch_ne;
  assign bus.pc_src        = pc_src;
  assign bus.alu_src       = alu_src;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write;
  assign bus.active        = reset & (state_q != S_HALT);
  assign bus.fault         = fault_q;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Bench for mips_multicycle_sequencer: instruction-level trace model expanded into per-cycle
// {inputs, expected outputs} records, directed plus random programs, and an async-reset sequence.
module tb_mips_multicycle_sequencer;

  localparam int MAXW = 3;

  localparam logic [16:0] MR      = 17'h10000;
  localparam logic [16:0] MW      = 17'h08000;
  localparam logic [16:0] AS      = 17'h04000;
  localparam logic [16:0] IRW     = 17'h02000;
  localparam logic [16:0] PW      = 17'h01000;
  localparam logic [16:0] PWC     = 17'h00800;
  localparam logic [16:0] BNEB    = 17'h00400;
  localparam logic [16:0] PS_BR   = 17'h00100;
  localparam logic [16:0] PS_J    = 17'h00200;
  localparam logic [16:0] PS_JR   = 17'h00300;
  localparam logic [16:0] ALUS    = 17'h00080;
  localparam logic [16:0] RD_RD   = 17'h00020;
  localparam logic [16:0] RD_31   = 17'h00040;
  localparam logic [16:0] M2R_MEM = 17'h00008;
  localparam logic [16:0] M2R_PC  = 17'h00010;
  localparam logic [16:0] RW      = 17'h00004;
  localparam logic [16:0] ACT     = 17'h00002;
  localparam logic [16:0] FLT     = 17'h00001;

  localparam int K_ILL = 0, K_R = 1, K_JR = 2, K_I = 3, K_LD = 4, K_ST = 5, K_BR = 6, K_J = 7, K_JAL = 8;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        pz;
    logic        wr;
    logic [16:0] exp;
    string       nm;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_sequencer_if bus ();

  mips_multicycle_sequencer #(.MAX_WAIT(MAXW), .WAIT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vec_t prog[$];
  bit   flt;
  bit   halted;
  int   nvec = 0;
  int   nerr = 0;

  function automatic logic [16:0] got();
    return {bus.mem_read, bus.mem_write, bus.addr_sel, bus.ir_write, bus.pc_write,
            bus.pc_write_cond, bus.branch_ne, bus.pc_src, bus.alu_src, bus.reg_dst,
            bus.mem_to_reg, bus.reg_write, bus.active, bus.fault};
  endfunction

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03}) return K_R;
      return (fn == 6'h08) ? K_JR : K_ILL;
    end
    if (op[5:3] == 3'b001) return K_I;
    if (op[5:3] == 3'b100) return K_LD;
    case (op)
      6'h2B:        return K_ST;
      6'h04, 6'h05: return K_BR;
      6'h02:        return K_J;
      6'h03:        return K_JAL;
      default:      return K_ILL;
    endcase
  endfunction

  task automatic push(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic pz, input logic wr, input logic [16:0] e, input string nm);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.pz = pz; v.wr = wr; v.exp = e;
    v.nm = $sformatf("%s#%0d", nm, prog.size());
    prog.push_back(v);
  endtask

  task automatic halt_tail(input string nm);
    for (int i = 0; i < 3; i++) push(1'b1, r6(), r6(), r1(), r1(), flt ? FLT : 17'h0, {nm, ":halt"});
    halted = 1'b1;
  endtask

  task automatic do_reset();
    push(1'b0, r6(), r6(), r1(), r1(), 17'h0, "in_reset");
    push(1'b0, r6(), r6(), r1(), r1(), 17'h0, "in_reset");
    flt    = 1'b0;
    halted = 1'b0;
    push(1'b1, r6(), r6(), r1(), r1(), ACT, "reset_state");
  endtask

  // One bus access lasting w stalls; MAXW or more stalls end in a timeout halt.
  task automatic access(input logic [16:0] strobe, input logic [16:0] done_x, input int w,
                        input logic [5:0] op, input logic [5:0] fn, input bit rnd_op,
                        input string nm);
    int n;
    n = (w >= MAXW) ? MAXW : w;
    for (int i = 0; i < n; i++)
      push(1'b1, rnd_op ? r6() : op, rnd_op ? r6() : fn, 1'b0, 1'b1, strobe | ACT, {nm, ":stall"});
    if (w >= MAXW) begin
      flt = 1'b1;
      halt_tail({nm, ":timeout"});
    end else begin
      push(1'b1, rnd_op ? r6() : op, rnd_op ? r6() : fn, 1'b0, 1'b0, strobe | done_x | ACT, {nm, ":done"});
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm,
                       input string nm);
    int k;
    if (halted) return;
    access(MR, IRW | PW, wf, op, fn, 1'b1, {nm, ":fetch"});
    if (halted) return;
    push(1'b1, op, fn, r1(), r1(), ACT, {nm, ":decode"});
    k = kind(op, fn);
    case (k)
      K_ILL: begin
        flt = 1'b1;
        halt_tail({nm, ":illegal"});
      end
      K_R: begin
        push(1'b1, op, fn, r1(), r1(), ACT, {nm, ":exec"});
        push(1'b1, op, fn, r1(), r1(), RW | RD_RD | ACT, {nm, ":wb"});
      end
      K_I: begin
        push(1'b1, op, fn, r1(), r1(), ALUS | ACT, {nm, ":exec"});
        push(1'b1, op, fn, r1(), r1(), RW | ACT, {nm, ":wb"});
      end
      K_LD: begin
        push(1'b1, op, fn, r1(), r1(), ALUS | ACT, {nm, ":exec"});
        access(MR | AS, 17'h0, wm, op, fn, 1'b0, {nm, ":mem"});
        if (!halted) push(1'b1, op, fn, r1(), r1(), RW | M2R_MEM | ACT, {nm, ":wb"});
      end
      K_ST: begin
        push(1'b1, op, fn, r1(), r1(), ALUS | ACT, {nm, ":exec"});
        access(MW | AS, 17'h0, wm, op, fn, 1'b0, {nm, ":mem"});
      end
      K_BR: push(1'b1, op, fn, r1(), r1(), PWC | PS_BR | (op[0] ? BNEB : 17'h0) | ACT, {nm, ":exec"});
      K_J:  push(1'b1, op, fn, r1(), r1(), PW | PS_J | ACT, {nm, ":exec"});
      K_JR: push(1'b1, op, fn, r1(), r1(), PW | PS_JR | ACT, {nm, ":exec"});
      default: begin
        push(1'b1, op, fn, r1(), r1(), PW | PS_J | ACT, {nm, ":exec"});
        push(1'b1, op, fn, r1(), r1(), RW | RD_31 | M2R_PC | ACT, {nm, ":wb"});
      end
    endcase
  endtask

  task automatic pc_zero_fetch(input string nm);
    if (halted) return;
    push(1'b1, r6(), r6(), 1'b1, r1(), ACT, {nm, ":pcz"});
    halt_tail(nm);
  endtask

  function automatic int rwait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 18) return $urandom_range(1, 2);
    return $urandom_range(3, 4);
  endfunction

  logic [5:0] legal_op[12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0D, 6'h23, 6'h20, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [5:0] legal_fn[11] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};

  initial begin
    logic [5:0] op, fn;
    bus.opcode = '0; bus.funct = '0; bus.pc_is_zero = 1'b0; bus.waitrequest = 1'b0;

    // Directed programs.
    do_reset();
    instr(6'h00, 6'h21, 0, 0, "addu");
    instr(6'h23, 6'h00, 0, 2, "lw_w2");
    instr(6'h2B, 6'h00, 0, 1, "sw_w1");
    instr(6'h05, 6'h00, 0, 0, "bne");
    instr(6'h04, 6'h00, 1, 0, "beq");
    instr(6'h03, 6'h00, 0, 0, "jal");
    instr(6'h02, 6'h00, 2, 0, "j");
    instr(6'h08, 6'h00, 0, 0, "addi");
    instr(6'h00, 6'h00, 0, 0, "sll");
    instr(6'h00, 6'h08, 0, 0, "jr");
    pc_zero_fetch("jr_then_pc0");
    do_reset();
    instr(6'h3F, 6'h00, 0, 0, "op3f");
    do_reset();
    instr(6'h00, 6'h21, 5, 0, "fetch_timeout");
    do_reset();
    instr(6'h00, 6'h01, 0, 0, "bad_funct");
    do_reset();
    instr(6'h2B, 6'h00, 0, 4, "sw_timeout");

    // Random programs.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (halted) do_reset();
      if ($urandom_range(0, 29) == 0) begin
        pc_zero_fetch("rnd_pcz");
      end else begin
        op = ($urandom_range(0, 9) < 8) ? legal_op[$urandom_range(0, 11)] : r6();
        fn = ($urandom_range(0, 9) < 8) ? legal_fn[$urandom_range(0, 10)] : r6();
        instr(op, fn, rwait(), rwait(), "rnd");
      end
    end

    foreach (prog[i]) begin
      @(posedge clk); #1;
      reset           = prog[i].rst;
      bus.opcode      = prog[i].op;
      bus.funct       = prog[i].fn;
      bus.pc_is_zero  = prog[i].pz;
      bus.waitrequest = prog[i].wr;
      @(negedge clk);
      check(prog[i].nm, got(), prog[i].exp);
    end

    // Asynchronous reset while a store is stalled in MEM.
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1; bus.pc_is_zero = 1'b0; bus.waitrequest = 1'b0;
    @(negedge clk); check("arst_reset_state", got(), ACT);
    @(posedge clk); #1 bus.opcode = r6(); bus.funct = r6();
    @(negedge clk); check("arst_fetch", got(), MR | IRW | PW | ACT);
    @(posedge clk); #1 bus.opcode = 6'h2B; bus.funct = 6'h00;
    @(negedge clk); check("arst_decode", got(), ACT);
    @(posedge clk); #1;
    @(negedge clk); check("arst_exec", got(), ALUS | ACT);
    @(posedge clk); #1 bus.waitrequest = 1'b1;
    @(negedge clk); check("arst_mem_stall", got(), MW | AS | ACT);
    #1 reset = 1'b0;
    #1 check("arst_drop_now", got(), 17'h0);
    @(posedge clk); #1 reset = 1'b1; bus.waitrequest = 1'b0;
    @(negedge clk); check("arst_restart", got(), ACT);
    @(posedge clk); #1;
    @(negedge clk); check("arst_refetch", got(), MR | IRW | PW | ACT);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_sequencer.md
Name: mips_multicycle_sequencer

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Issues reads and writes on the single shared memory bus and stalls on waitrequest.
- Drives the enable and select signals for the PC, IR, register file and ALU muxes, and stops the CPU on a jump to address 0 or on a fault.

Parameters:
- MAX_WAIT, 0: maximum consecutive waitrequest cycles per bus access; 0 means no limit.
- WAIT_W, 8: width of the wait counter; must satisfy MAX_WAIT < 2^WAIT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- pc_is_zero  in  1  current PC == 0x00000000.
- waitrequest  in  1  memory stall; an access completes in a cycle where it is 0.
- mem_read  out  1  bus read strobe.
- mem_write  out  1  bus write strobe.
- addr_sel  out  1  bus address source: 0 = PC, 1 = ALU result.
- ir_write  out  1  load IR from readdata.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if the branch condition holds.
- branch_ne  out  1  branch condition: 0 = ALU zero (BEQ), 1 = not zero (BNE).
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs (JR).
- alu_src  out  1  ALU B operand: 0 = rt, 1 = sign-extended immediate.
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31.
- mem_to_reg  out  2  00 = ALU result, 01 = memory data, 10 = PC+4 (link).
- reg_write  out  1  register file write enable.
- active  out  1  CPU running.
- fault  out  1  sticky: illegal opcode or bus timeout.

Behaviour:
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT.
- While reset = 0: state = RESET, wait counter = 0, fault = 0, and all outputs = 0 except active = 0.
- After reset deasserts: RESET lasts exactly one cycle with active = 1 and all other outputs 0, then FETCH.
- Outputs are combinational from state, opcode, funct and waitrequest. active = 1 in every state except HALT.
- FETCH:
  - If pc_is_zero = 1: go to HALT, with no bus access.
  - Otherwise assert mem_read = 1 and addr_sel = 0.
  - In the cycle waitrequest = 0, also assert ir_write = 1, pc_write = 1 and pc_src = 00, then go to DECODE.
  - While waitrequest = 1, stay in FETCH with no IR or PC write.
- DECODE: one cycle, no strobes.
  - Classify the instruction.
  - An unsupported opcode, or opcode 0 with an unsupported funct, goes to HALT and sets fault.
  - All others go to EXEC.
- Supported instructions:
  - R-type, opcode 000000, funct in {ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR}.
  - I-ALU, opcode[5:3] = 001.
  - Loads, opcode[5:3] = 100.
  - SW, 101011.
  - BEQ 000100, BNE 000101, J 000010, JAL 000011.
- EXEC: one cycle; action by class.
  - R-type: alu_src = 0, then WB.
  - I-ALU: alu_src = 1, then WB.
  - Load or store: alu_src = 1 (address calculation), then MEM.
  - BEQ/BNE: pc_write_cond = 1, pc_src = 01, branch_ne = opcode[0], then FETCH.
  - J: pc_write = 1, pc_src = 10, then FETCH.
  - JR: pc_write = 1, pc_src = 11, then FETCH.
  - JAL: pc_write = 1, pc_src = 10, then WB. The link value is PC+4, captured before the jump.
- MEM:
  - Assert addr_sel = 1 plus mem_read (load) or mem_write (store), held for the whole state.
  - In the cycle waitrequest = 0: a load goes to WB, a store goes to FETCH.
- WB: reg_write = 1 for exactly one cycle, then FETCH.
  - R-type: reg_dst = 01, mem_to_reg = 00.
  - I-ALU: reg_dst = 00, mem_to_reg = 00.
  - Load: reg_dst = 00, mem_to_reg = 01.
  - JAL: reg_dst = 10, mem_to_reg = 10.
- Wait counter:
  - Cleared on entry to FETCH or MEM and whenever waitrequest = 0.
  - Increments each cycle waitrequest = 1 during a bus access, saturating.
  - If MAX_WAIT != 0 and the counter reaches MAX_WAIT while waitrequest = 1: go to HALT next cycle, set fault, deassert the strobe.
- HALT: absorbing; all outputs 0 except fault, which holds its value. Only reset exits HALT.
- Asynchronous reset during any state, including a stalled MEM: strobes drop immediately and the FSM returns to RESET with no partial register or PC write.
- Latency with zero wait states:
  - ALU ops: 4 cycles.
  - Loads: 5 cycles.
  - Stores: 4 cycles.
  - Branches, J and JR: 3 cycles.
  - JAL: 4 cycles.
  - Add the wait-state cycles of each bus access to these figures.

Test Plan:
- Release reset with pc_is_zero = 0 and waitrequest = 0 → RESET for 1 cycle, then mem_read = 1 with addr_sel = 0 on the next cycle; ADDU (opcode 0, funct 100001) runs FETCH, DECODE, EXEC, WB and reg_write pulses with reg_dst = 01 in cycle 4.
- LW (100011) with waitrequest = 1 for 2 MEM cycles → mem_read held 3 cycles with addr_sel = 1, then one reg_write cycle with mem_to_reg = 01; SW (101011) → mem_write held until waitrequest = 0, then FETCH with no reg_write.
- BNE (000101) → EXEC asserts pc_write_cond = 1, branch_ne = 1, pc_src = 01, and the next state is FETCH; JAL → pc_write with pc_src = 10 in EXEC, then reg_write with reg_dst = 10 and mem_to_reg = 10.
- JR followed by pc_is_zero = 1 in FETCH → no mem_read; active falls to 0 the next cycle and fault stays 0.
- Opcode 111111 → HALT after DECODE with fault = 1; with MAX_WAIT = 3 and waitrequest stuck at 1 in FETCH → HALT with fault = 1 after 3 stalled cycles.
- Drive reset low in the middle of a stalled MEM store → mem_write drops without waiting for a clock edge; after release, the FSM restarts at RESET and then FETCH.
